// File: rtl/l2_bus_arbiter.sv
// L2 bus arbiter: shares one L2 bus between I-fill, D-fill/RFO and WB requesters.
// WB has priority with a streak cap; I and D alternate. Optional watchdog: L2_ARB_TIMEOUT_EN.
module l2_bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int WB_STREAK_MAX = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rfo,
    output logic              d_gnt,
    output logic              d_done,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              wb_gnt,
    output logic              wb_done,
    output logic              l2_valid,
    output logic [1:0]        l2_op,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_ready,
    input  logic              l2_done,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_I, OWN_D, OWN_WB} owner_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RFO   = 2'd2;

    localparam int SW = (WB_STREAK_MAX > 0) ? $clog2(WB_STREAK_MAX + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX_C = SW'(WB_STREAK_MAX);

    state_t            state_q;
    owner_t            owner_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rr_ptr_q;
    logic [SW-1:0]     wb_streak_q;

    logic              grant_d;
    owner_t            owner_d;
    logic [1:0]        op_d;
    logic [ADDR_W-1:0] addr_d;
    logic              wb_blocked;

`ifdef L2_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wdog_q;
    logic             timeout_err_q;
    logic             wdog_expired;

    // Expires on the TIMEOUT-th cycle spent in REQ/WAIT.
    assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT - 1));
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = 1'b0;
`endif

    // Owner selection, only consumed in IDLE.
    always_comb begin
        grant_d    = 1'b0;
        owner_d    = OWN_I;
        op_d       = OP_READ;
        addr_d     = i_addr;
        wb_blocked = (wb_streak_q == STREAK_MAX_C) && (i_req || d_req);
        if (wb_req && !wb_blocked) begin
            grant_d = 1'b1;
            owner_d = OWN_WB;
            op_d    = OP_WRITE;
            addr_d  = wb_addr;
        end else if (i_req && (!d_req || !rr_ptr_q)) begin
            grant_d = 1'b1;
            owner_d = OWN_I;
            op_d    = OP_READ;
            addr_d  = i_addr;
        end else if (d_req) begin
            grant_d = 1'b1;
            owner_d = OWN_D;
            op_d    = d_rfo ? OP_RFO : OP_READ;
            addr_d  = d_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_I;
            op_q          <= OP_READ;
            addr_q        <= '0;
            rr_ptr_q      <= 1'b0;
            wb_streak_q   <= '0;
`ifdef L2_ARB_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef L2_ARB_TIMEOUT_EN
                    wdog_q <= '0;
`endif
                    if (grant_d) begin
                        state_q <= ST_REQ;
                        owner_q <= owner_d;
                        op_q    <= op_d;
                        addr_q  <= addr_d;
                        if (owner_d == OWN_WB) begin
                            if (wb_streak_q != STREAK_MAX_C)
                                wb_streak_q <= wb_streak_q + 1'b1;
                        end else begin
                            wb_streak_q <= '0;
                            rr_ptr_q    <= (owner_d == OWN_I);
                        end
                    end
                end
                ST_REQ: begin
`ifdef L2_ARB_TIMEOUT_EN
                    wdog_q <= wdog_q + 1'b1;
                    if (wdog_expired) begin
                        state_q       <= ST_DONE;
                        timeout_err_q <= 1'b1;
                    end else
`endif
                    if (l2_ready)
                        state_q <= ST_WAIT;
                end
                ST_WAIT: begin
`ifdef L2_ARB_TIMEOUT_EN
                    wdog_q <= wdog_q + 1'b1;
                    if (wdog_expired) begin
                        state_q       <= ST_DONE;
                        timeout_err_q <= 1'b1;
                    end else
`endif
                    if (l2_done)
                        state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only.
    assign busy     = (state_q != ST_IDLE);
    assign l2_valid = (state_q == ST_REQ);
    assign l2_op    = op_q;
    assign l2_addr  = addr_q;
    assign i_gnt    = busy && (owner_q == OWN_I);
    assign d_gnt    = busy && (owner_q == OWN_D);
    assign wb_gnt   = busy && (owner_q == OWN_WB);
    assign i_done   = (state_q == ST_DONE) && (owner_q == OWN_I);
    assign d_done   = (state_q == ST_DONE) && (owner_q == OWN_D);
    assign wb_done  = (state_q == ST_DONE) && (owner_q == OWN_WB);

endmodule
